// File: rtl/fetch_mem_arbiter.sv
// fetch_mem_arbiter
// Shares one single-port, fixed-latency memory between instruction fetch (IF)
// and the load/store unit (LS). One transaction may be outstanding at a time.
// LS has priority, bounded by a streak limit so a waiting fetch is not starved.
// A branch flush kills an in-flight fetch response without cancelling the
// memory access, so occupancy timing does not change.
//
// Ports
//   clk, reset_n      clock, asynchronous active-low reset
//   if_req_i          fetch request, held until if_gnt_o
//   if_addr_i         fetch address (PC)
//   if_flush_i        kill any in-flight fetch response
//   if_gnt_o          fetch accepted this cycle (combinational)
//   if_rvalid_o       fetch data valid (combinational)
//   if_rdata_o        instruction word, 0 when not valid
//   if_stall_o        IF must hold PC (combinational)
//   ls_req_i          load/store request, held until ls_gnt_o
//   ls_we_i           1 = store
//   ls_be_i           store byte enables
//   ls_addr_i         data address
//   ls_wdata_i        store data
//   ls_gnt_o          LS accepted this cycle (combinational)
//   ls_rvalid_o       load data valid or store acknowledge (combinational)
//   ls_rdata_o        load data, 0 for store acknowledges and when not valid
//   mem_req_o         memory access strobe, asserted in the grant cycle
//   mem_we_o          memory write
//   mem_be_o          memory byte enables
//   mem_addr_o        memory address
//   mem_wdata_o       memory write data
//   mem_rdata_i       memory read data, valid MEM_LATENCY cycles after mem_req_o
//
// Parameters
//   MEM_LATENCY       cycles from grant to read data, 1..15
//   MAX_LS_STREAK     consecutive LS grants allowed while IF waits, 1..3

module fetch_mem_arbiter #(
    parameter int unsigned MEM_LATENCY   = 2,
    parameter int unsigned MAX_LS_STREAK = 2
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    input  logic        if_flush_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    output logic        if_stall_o,

    input  logic        ls_req_i,
    input  logic        ls_we_i,
    input  logic [3:0]  ls_be_i,
    input  logic [31:0] ls_addr_i,
    input  logic [31:0] ls_wdata_i,
    output logic        ls_gnt_o,
    output logic        ls_rvalid_o,
    output logic [31:0] ls_rdata_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned STREAK_W = 2;
    localparam logic [CNT_W-1:0]    LAT_CNT    = CNT_W'(MEM_LATENCY);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LS_STREAK);
    localparam logic [STREAK_W-1:0] STREAK_SAT = '1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t                state;
    logic                  owner_ls;   // 1: outstanding access belongs to LS
    logic                  is_store;   // outstanding LS access is a store
    logic [CNT_W-1:0]      cnt;
    logic                  kill;
    logic [STREAK_W-1:0]   ls_streak;

    logic resp;
    logic eligible;
    logic ls_wins;
    logic grant_if;
    logic grant_ls;

    // Response / grant-opportunity decode and arbitration.
    always_comb begin
        resp     = reset_n && (state == S_WAIT) && (cnt == LAT_CNT);
        eligible = reset_n && ((state == S_IDLE) || resp);
        // LS takes the slot unless IF is waiting and LS has used up its streak.
        ls_wins  = ls_req_i && (!if_req_i || (ls_streak != STREAK_MAX));
        grant_ls = eligible && ls_wins;
        grant_if = eligible && if_req_i && !ls_wins;
    end

    // Memory strobe and payload mux; all zero when no grant.
    always_comb begin
        mem_req_o   = grant_if || grant_ls;
        mem_we_o    = grant_ls && ls_we_i;
        mem_be_o    = 4'h0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        if (grant_ls) begin
            mem_be_o    = ls_be_i;
            mem_addr_o  = ls_addr_i;
            mem_wdata_o = ls_wdata_i;
        end else if (grant_if) begin
            mem_be_o    = 4'hF;
            mem_addr_o  = if_addr_i;
        end
    end

    // Grant, response and stall outputs.
    always_comb begin
        if_gnt_o    = grant_if;
        ls_gnt_o    = grant_ls;
        // A flush in the response cycle itself also suppresses the fetch data.
        if_rvalid_o = resp && !owner_ls && !kill && !if_flush_i;
        if_rdata_o  = if_rvalid_o ? mem_rdata_i : 32'h0;
        ls_rvalid_o = resp && owner_ls;
        ls_rdata_o  = (ls_rvalid_o && !is_store) ? mem_rdata_i : 32'h0;
        if_stall_o  = reset_n && if_req_i && !if_rvalid_o;
    end

    // Transaction tracking state machine.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            owner_ls  <= 1'b0;
            is_store  <= 1'b0;
            cnt       <= '0;
            kill      <= 1'b0;
            ls_streak <= '0;
        end else if (grant_if || grant_ls) begin
            state    <= S_WAIT;
            owner_ls <= grant_ls;
            is_store <= grant_ls && ls_we_i;
            cnt      <= CNT_W'(1);
            kill     <= grant_if && if_flush_i;
            if (grant_if || !if_req_i) begin
                ls_streak <= '0;
            end else if (ls_streak != STREAK_SAT) begin
                ls_streak <= ls_streak + STREAK_W'(1);
            end
        end else if (resp) begin
            state    <= S_IDLE;
            owner_ls <= 1'b0;
            is_store <= 1'b0;
            cnt      <= '0;
            kill     <= 1'b0;
        end else if (state == S_WAIT) begin
            cnt <= cnt + CNT_W'(1);
            if (!owner_ls && if_flush_i) begin
                kill <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Bench for fetch_mem_arbiter: directed scenarios followed by randomized
// traffic, all checked each cycle against a transaction-level reference model
// that tracks the outstanding access by its absolute due cycle.

module tb_fetch_mem_arbiter;

    localparam int LAT  = 2;
    localparam int MAXS = 2;

    logic        clk;
    logic        reset_n;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_flush_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        if_stall_o;
    logic        ls_req_i;
    logic        ls_we_i;
    logic [3:0]  ls_be_i;
    logic [31:0] ls_addr_i;
    logic [31:0] ls_wdata_i;
    logic        ls_gnt_o;
    logic        ls_rvalid_o;
    logic [31:0] ls_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    fetch_mem_arbiter #(
        .MEM_LATENCY  (LAT),
        .MAX_LS_STREAK(MAXS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_flush_i (if_flush_i),
        .if_gnt_o   (if_gnt_o),
        .if_rvalid_o(if_rvalid_o),
        .if_rdata_o (if_rdata_o),
        .if_stall_o (if_stall_o),
        .ls_req_i   (ls_req_i),
        .ls_we_i    (ls_we_i),
        .ls_be_i    (ls_be_i),
        .ls_addr_i  (ls_addr_i),
        .ls_wdata_i (ls_wdata_i),
        .ls_gnt_o   (ls_gnt_o),
        .ls_rvalid_o(ls_rvalid_o),
        .ls_rdata_o (ls_rdata_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_be_o   (mem_be_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: one outstanding access described by who owns it,
    // whether it is a store, whether it was killed, and the cycle it returns.
    int cyc        = 0;
    bit m_busy     = 0;
    int m_due      = 0;
    bit m_owner_ls = 0;
    bit m_store    = 0;
    bit m_killed   = 0;
    int m_streak   = 0;
    bit m_gnt_if   = 0;
    bit m_gnt_ls   = 0;

    int seq[$];
    int exp4[6] = '{1, 1, 0, 1, 1, 0};
    int seen_rv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Let combinational outputs settle mid-cycle.
    task automatic look();
        #2;
    endtask

    // Compare all outputs with the model, then advance one clock.
    task automatic step();
        bit rst, resp, elig, g_if, g_ls, rv_if, rv_ls, we;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_be;
        rst  = !reset_n;
        resp = !rst && m_busy && (cyc == m_due);
        elig = !rst && (!m_busy || resp);
        g_if = 0;
        g_ls = 0;
        if (elig) begin
            if (if_req_i && ls_req_i) begin
                if (m_streak == MAXS) g_if = 1;
                else                  g_ls = 1;
            end else if (if_req_i) begin
                g_if = 1;
            end else if (ls_req_i) begin
                g_ls = 1;
            end
        end
        rv_if   = resp && !m_owner_ls && !m_killed && !if_flush_i;
        rv_ls   = resp && m_owner_ls;
        we      = g_ls && ls_we_i;
        e_addr  = g_ls ? ls_addr_i  : (g_if ? if_addr_i : 32'h0);
        e_wdata = g_ls ? ls_wdata_i : 32'h0;
        e_be    = g_ls ? ls_be_i    : (g_if ? 4'hF : 4'h0);

        chk("if_gnt",    32'(if_gnt_o),    32'(g_if));
        chk("ls_gnt",    32'(ls_gnt_o),    32'(g_ls));
        chk("mem_req",   32'(mem_req_o),   32'(g_if || g_ls));
        chk("mem_we",    32'(mem_we_o),    32'(we));
        chk("mem_be",    32'(mem_be_o),    32'(e_be));
        chk("mem_addr",  mem_addr_o,       e_addr);
        chk("mem_wdata", mem_wdata_o,      e_wdata);
        chk("if_rvalid", 32'(if_rvalid_o), 32'(rv_if));
        chk("if_rdata",  if_rdata_o,       rv_if ? mem_rdata_i : 32'h0);
        chk("if_stall",  32'(if_stall_o),  32'(!rst && if_req_i && !rv_if));
        chk("ls_rvalid", 32'(ls_rvalid_o), 32'(rv_ls));
        chk("ls_rdata",  ls_rdata_o,       (rv_ls && !m_store) ? mem_rdata_i : 32'h0);

        @(posedge clk);
        #1;
        if (rst) begin
            m_busy     = 0;
            m_owner_ls = 0;
            m_store    = 0;
            m_killed   = 0;
            m_streak   = 0;
        end else if (g_if || g_ls) begin
            m_busy     = 1;
            m_due      = cyc + LAT;
            m_owner_ls = g_ls;
            m_store    = we;
            m_killed   = g_if && if_flush_i;
            if (g_if || !if_req_i) m_streak = 0;
            else                   m_streak = (m_streak < 3) ? m_streak + 1 : 3;
        end else if (resp) begin
            m_busy = 0;
        end else if (m_busy && !m_owner_ls && if_flush_i) begin
            m_killed = 1;
        end
        m_gnt_if = g_if;
        m_gnt_ls = g_ls;
        cyc++;
    endtask

    task automatic tick();
        mem_rdata_i = $urandom;
        look();
        step();
    endtask

    initial begin
        reset_n     = 1'b0;
        if_req_i    = 1'b0;
        if_addr_i   = 32'h0;
        if_flush_i  = 1'b0;
        ls_req_i    = 1'b0;
        ls_we_i     = 1'b0;
        ls_be_i     = 4'h0;
        ls_addr_i   = 32'h0;
        ls_wdata_i  = 32'h0;
        mem_rdata_i = 32'h0;
        @(posedge clk);
        #1;

        // Reset held, then quiet release.
        for (int i = 0; i < 3; i++) tick();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();

        // Single fetch; IF keeps requesting the next PC.
        if_req_i    = 1'b1;
        if_addr_i   = 32'h100;
        mem_rdata_i = 32'h00500093;
        look();
        chk("t2_gnt",   32'(if_gnt_o),   32'd1);
        chk("t2_addr",  mem_addr_o,      32'h100);
        chk("t2_we",    32'(mem_we_o),   32'd0);
        chk("t2_stall", 32'(if_stall_o), 32'd1);
        step();
        if_addr_i = 32'h104;
        look();
        chk("t2_stall1", 32'(if_stall_o), 32'd1);
        step();
        look();
        chk("t2_rvalid", 32'(if_rvalid_o), 32'd1);
        chk("t2_rdata",  if_rdata_o,       32'h00500093);
        step();
        if_req_i = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Simultaneous LS load and fetch.
        ls_req_i  = 1'b1;
        ls_we_i   = 1'b0;
        ls_be_i   = 4'hF;
        ls_addr_i = 32'h2000;
        if_req_i  = 1'b1;
        if_addr_i = 32'h104;
        mem_rdata_i = $urandom;
        look();
        chk("t3_lsgnt", 32'(ls_gnt_o), 32'd1);
        chk("t3_ifgnt", 32'(if_gnt_o), 32'd0);
        step();
        ls_req_i = 1'b0;
        tick();
        mem_rdata_i = $urandom;
        look();
        chk("t3_lsrv",  32'(ls_rvalid_o), 32'd1);
        chk("t3_ifgnt2", 32'(if_gnt_o),   32'd1);
        step();
        if_req_i = 1'b0;
        tick();
        mem_rdata_i = $urandom;
        look();
        chk("t3_ifrv", 32'(if_rvalid_o), 32'd1);
        step();
        for (int i = 0; i < 2; i++) tick();

        // Both requesting continuously: streak limit interleaves IF.
        ls_req_i  = 1'b1;
        if_req_i  = 1'b1;
        seq.delete();
        for (int i = 0; i < 12; i++) begin
            mem_rdata_i = $urandom;
            look();
            if (ls_gnt_o)      seq.push_back(1);
            else if (if_gnt_o) seq.push_back(0);
            step();
            if (m_gnt_ls) ls_addr_i = ls_addr_i + 32'd4;
            if (m_gnt_if) if_addr_i = if_addr_i + 32'd4;
        end
        chk("t4_count", 32'(seq.size()), 32'd6);
        for (int i = 0; i < 6 && i < seq.size(); i++) chk("t4_winner", 32'(seq[i]), 32'(exp4[i]));
        ls_req_i = 1'b0;
        if_req_i = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Flush kills the in-flight fetch; the next fetch returns normally.
        if_req_i  = 1'b1;
        if_addr_i = 32'h200;
        mem_rdata_i = $urandom;
        look();
        chk("t5_gnt", 32'(if_gnt_o), 32'd1);
        step();
        if_req_i   = 1'b0;
        if_flush_i = 1'b1;
        tick();
        if_flush_i = 1'b0;
        if_req_i   = 1'b1;
        if_addr_i  = 32'h300;
        mem_rdata_i = $urandom;
        look();
        chk("t5_killed", 32'(if_rvalid_o), 32'd0);
        chk("t5_gnt2",   32'(if_gnt_o),    32'd1);
        chk("t5_addr2",  mem_addr_o,       32'h300);
        step();
        if_req_i = 1'b0;
        tick();
        mem_rdata_i = $urandom;
        look();
        chk("t5_rv2", 32'(if_rvalid_o), 32'd1);
        step();
        for (int i = 0; i < 2; i++) tick();

        // Store interrupted by reset; no acknowledge ever appears.
        ls_req_i   = 1'b1;
        ls_we_i    = 1'b1;
        ls_be_i    = 4'b0011;
        ls_addr_i  = 32'h3000;
        ls_wdata_i = 32'h0000A5A5;
        mem_rdata_i = $urandom;
        look();
        chk("t6_gnt",   32'(ls_gnt_o),  32'd1);
        chk("t6_we",    32'(mem_we_o),  32'd1);
        chk("t6_be",    32'(mem_be_o),  32'h3);
        chk("t6_wdata", mem_wdata_o,    32'h0000A5A5);
        step();
        ls_req_i = 1'b0;
        ls_we_i  = 1'b0;
        reset_n  = 1'b0;
        tick();
        tick();
        reset_n   = 1'b1;
        if_req_i  = 1'b1;
        if_addr_i = 32'h400;
        mem_rdata_i = $urandom;
        look();
        chk("t6_first_gnt", 32'(if_gnt_o), 32'd1);
        step();
        if_req_i = 1'b0;
        seen_rv = 0;
        for (int i = 0; i < 4; i++) begin
            mem_rdata_i = $urandom;
            look();
            if (ls_rvalid_o) seen_rv++;
            step();
        end
        chk("t6_no_ack", 32'(seen_rv), 32'd0);

        // Randomized traffic with flushes and occasional resets.
        for (int k = 0; k < 600; k++) begin
            if (m_gnt_if) if_req_i = 1'b0;
            if (m_gnt_ls) ls_req_i = 1'b0;
            if (if_req_i && $urandom_range(0, 31) == 0) if_req_i = 1'b0;
            if (ls_req_i && $urandom_range(0, 31) == 0) ls_req_i = 1'b0;
            if (!if_req_i && $urandom_range(0, 2) != 0) begin
                if_req_i  = 1'b1;
                if_addr_i = $urandom & 32'hFFFF_FFFC;
            end
            if (!ls_req_i && $urandom_range(0, 2) != 0) begin
                ls_req_i   = 1'b1;
                ls_we_i    = 1'($urandom_range(0, 1));
                ls_be_i    = 4'($urandom_range(1, 15));
                ls_addr_i  = $urandom;
                ls_wdata_i = $urandom;
            end
            if_flush_i = ($urandom_range(0, 7) == 0);
            reset_n    = ($urandom_range(0, 99) != 0);
            tick();
        end

        reset_n    = 1'b1;
        if_req_i   = 1'b0;
        ls_req_i   = 1'b0;
        if_flush_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
